// File: rtl/cci_arb_pkg.sv
// Shared types for the CCI-P c0 read arbiter: tag/client widths, FSM states, mdata packing.
package cci_arb_pkg;

  // Upper bounds for the parameterised arbiter; actual widths are narrower slices.
  localparam int unsigned MaxTagW = 8;
  localparam int unsigned MaxReq  = 8;

  typedef logic [MaxTagW-1:0] t_tag;
  typedef logic [2:0]         t_client_id;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDrained
  } t_state;

  function automatic logic [15:0] pack_mdata(input t_tag tag);
    return {8'h00, tag};
  endfunction

endpackage

// File: rtl/tag_pool.sv
// Read-tag pool: in-use bitmap, lowest-free allocator, tag-to-client owner table and
// outstanding counter.
module tag_pool
  import cci_arb_pkg::*;
#(
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alloc_i,
  input  t_client_id       alloc_owner_i,
  output logic             free_avail_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             free_i,
  input  logic [TAG_W-1:0] free_tag_i,
  output logic             tag_in_use_o,
  output t_client_id       tag_owner_o,
  output logic [TAG_W:0]   outstanding_o
);

  localparam int unsigned NumTags = 2 ** TAG_W;
  localparam logic [TAG_W:0] CntOne = {{TAG_W{1'b0}}, 1'b1};

  logic [NumTags-1:0] in_use_q, in_use_d;
  logic [TAG_W:0]     outstanding_q, outstanding_d;
  t_client_id         owner_q [NumTags];

  // Priority encoder over the registered bitmap, so a tag freed this cycle is not reused
  // until the next one.
  always_comb begin
    alloc_tag_o  = '0;
    free_avail_o = 1'b0;
    for (int i = int'(NumTags) - 1; i >= 0; i--) begin
      if (!in_use_q[i]) begin
        alloc_tag_o  = TAG_W'(i);
        free_avail_o = 1'b1;
      end
    end
  end

  assign tag_in_use_o  = in_use_q[free_tag_i];
  assign tag_owner_o   = owner_q[free_tag_i];
  assign outstanding_o = outstanding_q;

  always_comb begin
    in_use_d      = in_use_q;
    outstanding_d = outstanding_q;
    if (alloc_i) begin
      in_use_d[alloc_tag_o] = 1'b1;
    end
    if (free_i) begin
      in_use_d[free_tag_i] = 1'b0;
    end
    unique case ({alloc_i, free_i})
      2'b10:   outstanding_d = outstanding_q + CntOne;
      2'b01:   outstanding_d = outstanding_q - CntOne;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_use_q      <= '0;
      outstanding_q <= '0;
    end else begin
      in_use_q      <= in_use_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Owner entries are only read while the matching in-use bit is set, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (alloc_i) begin
      owner_q[alloc_tag_o] <= alloc_owner_i;
    end
  end

endmodule

// File: rtl/cci_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read-request channel among client engines,
// with mdata tag allocation and response routing back to the issuing client.
module cci_rd_arbiter
  import cci_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned AW      = 64
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0][AW-1:0]  req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [511:0]                rsp_data,
  output logic                        c0_req_valid,
  output logic [AW-1:0]               c0_req_addr,
  output logic [15:0]                 c0_req_mdata,
  input  logic                        c0_alm_full,
  input  logic                        c0_rsp_valid,
  input  logic [15:0]                 c0_rsp_mdata,
  input  logic [511:0]                c0_rsp_data,
  input  logic                        drain,
  output logic                        drained,
  output logic [TAG_W:0]              outstanding,
  output logic                        err_unexp_rsp
);

  t_state               state_q, state_d;
  t_client_id           rr_q, rr_d;
  logic                 c0_req_valid_q;
  logic [AW-1:0]        c0_req_addr_q, c0_req_addr_d;
  logic [15:0]          c0_req_mdata_q;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [511:0]         rsp_data_q;
  logic                 err_q, err_d;

  logic                 found;
  t_client_id           winner;
  int unsigned          idx;
  logic                 grant_en, accept;
  logic                 free_avail;
  logic [TAG_W-1:0]     alloc_tag;
  logic [TAG_W-1:0]     rsp_tag;
  logic                 hdr_ok, tag_in_use, rsp_hit;
  t_client_id           tag_owner;
  logic [TAG_W:0]       outstanding_cnt;

  tag_pool #(
    .TAG_W (TAG_W)
  ) u_tag_pool (
    .clk_i         (CLK),
    .rst_ni        (RST_N),
    .alloc_i       (accept),
    .alloc_owner_i (winner),
    .free_avail_o  (free_avail),
    .alloc_tag_o   (alloc_tag),
    .free_i        (rsp_hit),
    .free_tag_i    (rsp_tag),
    .tag_in_use_o  (tag_in_use),
    .tag_owner_o   (tag_owner),
    .outstanding_o (outstanding_cnt)
  );

  // Round-robin search: first requester at or after rr_q, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = t_client_id'(idx);
      end
    end
  end

  assign grant_en = (state_q == StRun) && !c0_alm_full && free_avail;
  assign accept   = grant_en && found;

  always_comb begin
    req_ready     = '0;
    c0_req_addr_d = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (accept && (winner == t_client_id'(k))) begin
        req_ready[k]  = 1'b1;
        c0_req_addr_d = req_addr[k];
      end
    end
    rr_d = accept ? t_client_id'((int'(winner) + 1) % NUM_REQ) : rr_q;
  end

  // Nonzero mdata bits above the tag can never come from us, so treat them as unexpected.
  assign rsp_tag = c0_rsp_mdata[TAG_W-1:0];
  assign hdr_ok  = (c0_rsp_mdata >> TAG_W) == 16'h0000;
  assign rsp_hit = c0_rsp_valid && hdr_ok && tag_in_use;

  always_comb begin
    rsp_valid_d = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      rsp_valid_d[k] = rsp_hit && (tag_owner == t_client_id'(k));
    end
    err_d = err_q || (c0_rsp_valid && !rsp_hit);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (drain) state_d = StDrain;
      end
      StDrain: begin
        if (!drain) begin
          state_d = StRun;
        end else if (outstanding_cnt == '0) begin
          state_d = StDrained;
        end
      end
      StDrained: begin
        if (!drain) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= StRun;
      rr_q           <= '0;
      c0_req_valid_q <= 1'b0;
      c0_req_addr_q  <= '0;
      c0_req_mdata_q <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      c0_req_valid_q <= accept;
      rsp_valid_q    <= rsp_valid_d;
      err_q          <= err_d;
      if (accept) begin
        c0_req_addr_q  <= c0_req_addr_d;
        c0_req_mdata_q <= pack_mdata(t_tag'(alloc_tag));
      end
      if (rsp_hit) begin
        rsp_data_q <= c0_rsp_data;
      end
    end
  end

  assign c0_req_valid  = c0_req_valid_q;
  assign c0_req_addr   = c0_req_addr_q;
  assign c0_req_mdata  = c0_req_mdata_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign drained       = (state_q == StDrained);
  assign outstanding   = outstanding_cnt;
  assign err_unexp_rsp = err_q;

endmodule

// File: tb/tb_cci_rd_arbiter.sv
// Scoreboard bench for cci_rd_arbiter: directed stimulus queues expected c0 requests and
// client responses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_cci_rd_arbiter;

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic [3:0]           req_valid;
  logic [3:0][63:0]     req_addr;
  logic [3:0]           req_ready;
  logic [3:0]           rsp_valid;
  logic [511:0]         rsp_data;
  logic                 c0_req_valid;
  logic [63:0]          c0_req_addr;
  logic [15:0]          c0_req_mdata;
  logic                 c0_alm_full;
  logic                 c0_rsp_valid;
  logic [15:0]          c0_rsp_mdata;
  logic [511:0]         c0_rsp_data;
  logic                 drain;
  logic                 drained;
  logic [6:0]           outstanding;
  logic                 err_unexp_rsp;

  typedef struct {
    logic [63:0] addr;
    logic [15:0] mdata;
  } req_t;

  typedef struct {
    logic [3:0]   who;
    logic [511:0] data;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  cci_rd_arbiter #(
    .NUM_REQ (4),
    .TAG_W   (6),
    .AW      (64)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .c0_req_valid  (c0_req_valid),
    .c0_req_addr   (c0_req_addr),
    .c0_req_mdata  (c0_req_mdata),
    .c0_alm_full   (c0_alm_full),
    .c0_rsp_valid  (c0_rsp_valid),
    .c0_rsp_mdata  (c0_rsp_mdata),
    .c0_rsp_data   (c0_rsp_data),
    .drain         (drain),
    .drained       (drained),
    .outstanding   (outstanding),
    .err_unexp_rsp (err_unexp_rsp)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_data(input logic [15:0] md);
    logic [31:0] w;
    w = {16'hA5C3, md};
    return {16{w}};
  endfunction

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    @(negedge CLK);
    #1;
    RST_N        = 1'b0;
    req_valid    = '0;
    c0_alm_full  = 1'b0;
    c0_rsp_valid = 1'b0;
    c0_rsp_mdata = '0;
    c0_rsp_data  = '0;
    drain        = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic push_req(input logic [63:0] a, input int tag);
    req_t r;
    r.addr  = a;
    r.mdata = 16'(tag);
    exp_req.push_back(r);
  endtask

  // One response cycle; expect_hit queues the client-side response it should produce.
  task automatic rsp(input logic [15:0] md, input logic [3:0] who, input bit expect_hit);
    rsp_t r;
    c0_rsp_valid = 1'b1;
    c0_rsp_mdata = md;
    c0_rsp_data  = mk_data(md);
    if (expect_hit) begin
      r.who  = who;
      r.data = mk_data(md);
      exp_rsp.push_back(r);
    end
    step();
    c0_rsp_valid = 1'b0;
  endtask

  // Monitor: compares every presented request/response against the scoreboard.
  initial begin
    req_t er;
    rsp_t es;
    forever begin
      @(negedge CLK);
      if (RST_N === 1'b1) begin
        if (c0_req_valid) begin
          if (exp_req.size() == 0) begin
            chk("c0_req_unexpected", {c0_req_addr, c0_req_mdata}, '0);
          end else begin
            er = exp_req.pop_front();
            chk("c0_req_addr", c0_req_addr, er.addr);
            chk("c0_req_mdata", c0_req_mdata, er.mdata);
          end
        end
        if (rsp_valid != 4'b0000) begin
          if (exp_rsp.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, 4'b0000);
          end else begin
            es = exp_rsp.pop_front();
            chk("rsp_valid", rsp_valid, es.who);
            chk("rsp_data", rsp_data, es.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_addr = '0;
    do_reset();

    // Reset state
    chk("rst_outstanding", outstanding, 7'd0);
    chk("rst_c0_req_valid", c0_req_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_err", err_unexp_rsp, 1'b0);
    chk("rst_drained", drained, 1'b0);
    chk("rst_req_ready", req_ready, 4'b0000);

    // Single client 0 read and its response
    req_addr[0] = 64'h1000;
    req_valid   = 4'b0001;
    #1 chk("t1_ready", req_ready, 4'b0001);
    push_req(64'h1000, 0);
    step();
    req_valid = '0;
    chk("t1_outstanding1", outstanding, 7'd1);
    rsp(16'h0000, 4'b0001, 1'b1);
    chk("t1_outstanding0", outstanding, 7'd0);
    step();

    // All four clients valid for 8 cycles: round-robin order with tags 0..7
    do_reset();
    for (int k = 0; k < 4; k++) req_addr[k] = 64'h2000 + 64'(k) * 64'h40;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 chk("t2_ready", req_ready, 4'b0001 << (i % 4));
      push_req(64'h2000 + 64'(i % 4) * 64'h40, i);
      step();
    end
    req_valid = '0;
    chk("t2_outstanding8", outstanding, 7'd8);
    for (int t = 0; t < 8; t++) rsp(16'(t), 4'b0001 << (t % 4), 1'b1);
    step();
    chk("t2_outstanding0", outstanding, 7'd0);

    // Exhaust all 64 tags, then free tag 5 and see it reused
    do_reset();
    req_addr[2] = 64'h3000;
    req_valid   = 4'b0100;
    for (int i = 0; i < 64; i++) begin
      push_req(64'h3000, i);
      step();
    end
    chk("t3_outstanding64", outstanding, 7'd64);
    chk("t3_full_ready", req_ready, 4'b0000);
    c0_rsp_valid = 1'b1;
    c0_rsp_mdata = 16'd5;
    c0_rsp_data  = mk_data(16'd5);
    exp_rsp.push_back('{who: 4'b0100, data: mk_data(16'd5)});
    #1 chk("t3_ready_same_cycle_free", req_ready, 4'b0000);
    step();
    c0_rsp_valid = 1'b0;
    #1 chk("t3_ready_after_free", req_ready, 4'b0100);
    push_req(64'h3000, 5);
    step();
    req_valid = '0;
    chk("t3_outstanding_reuse", outstanding, 7'd64);
    step();

    // Almost-full blocks grants and holds the round-robin pointer
    do_reset();
    for (int k = 0; k < 4; k++) req_addr[k] = 64'h4000 + 64'(k) * 64'h40;
    req_valid = 4'b1111;
    #1 chk("t4_first_ready", req_ready, 4'b0001);
    push_req(64'h4000, 0);
    step();
    c0_alm_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_almfull_ready", req_ready, 4'b0000);
      step();
    end
    c0_alm_full = 1'b0;
    #1 chk("t4_resume_ready", req_ready, 4'b0010);
    push_req(64'h4040, 1);
    step();
    req_valid = '0;
    step();

    // Drain with three reads outstanding
    do_reset();
    for (int k = 0; k < 4; k++) req_addr[k] = 64'h5000 + 64'(k) * 64'h40;
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_ready", req_ready, 4'b0001 << i);
      push_req(64'h5000 + 64'(i) * 64'h40, i);
      step();
    end
    req_valid = '0;
    drain     = 1'b1;
    step();
    req_valid = 4'b1111;
    #1 chk("t5_drain_block", req_ready, 4'b0000);
    rsp(16'd0, 4'b0001, 1'b1);
    chk("t5_not_drained", drained, 1'b0);
    rsp(16'd1, 4'b0010, 1'b1);
    rsp(16'd2, 4'b0100, 1'b1);
    chk("t5_drained_early", drained, 1'b0);
    step();
    chk("t5_drained", drained, 1'b1);
    #1 chk("t5_drained_block", req_ready, 4'b0000);
    drain = 1'b0;
    #1 chk("t5_drained_still_block", req_ready, 4'b0000);
    step();
    chk("t5_run_again", drained, 1'b0);
    #1 chk("t5_resume_ready", req_ready, 4'b1000);
    push_req(64'h50C0, 0);
    step();
    req_valid = '0;
    step();

    // Nonzero upper mdata bits are unexpected even though tag 0 is in use
    rsp(16'h0100, 4'b0000, 1'b0);
    chk("t6_hdr_err", err_unexp_rsp, 1'b1);
    rsp(16'h0000, 4'b1000, 1'b1);
    step();
    chk("t6_outstanding0", outstanding, 7'd0);

    // Reset mid-operation forgets outstanding tags
    do_reset();
    chk("t6_err_cleared", err_unexp_rsp, 1'b0);
    req_valid = 4'b0010;
    push_req(64'h5040, 0);
    step();
    req_valid = '0;
    step();
    chk("t6_pre_reset_outstanding", outstanding, 7'd1);
    do_reset();
    chk("t6_post_reset_outstanding", outstanding, 7'd0);
    rsp(16'h0000, 4'b0000, 1'b0);
    chk("t6_stale_rsp_err", err_unexp_rsp, 1'b1);

    // Unused tag 9: dropped, sticky error
    do_reset();
    rsp(16'd9, 4'b0000, 1'b0);
    chk("t7_err_set", err_unexp_rsp, 1'b1);
    repeat (3) step();
    chk("t7_err_sticky", err_unexp_rsp, 1'b1);
    chk("t7_outstanding", outstanding, 7'd0);
    step();

    chk("sb_req_left", 32'(exp_req.size()), 32'd0);
    chk("sb_rsp_left", 32'(exp_rsp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
